c880_resp_misr: RTL and testbench

Response-side companion to the c880 stimulus bench: accepts the 26 primary outputs (G855..G880) of the c880 netlist once per applied pattern and compacts them into a 32-bit MISR signature. It also accumulates an output-toggle count for rare-node activity analysis. When the programmed pattern count is reached, it reports done, the signature, and a golden-compare result. It sits between the c880 UUT outputs and the bench/scoreboard.

---
 rtl/c880_tb_pkg.sv | 32 +++
 rtl/c880_resp_misr_step.sv | 29 ++
 rtl/c880_resp_misr.sv | 134 +++++++++++++
 tb/tb_c880_resp_misr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c880_tb_pkg.sv
// Shared types, constants and helpers for the c880 stimulus/response benches.
package c880_tb_pkg;

  // Capture-run state of the response compactor.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } misr_state_t;

  // c880 primary output / input widths.
  localparam int C880_RESP_W = 26;
  localparam int C880_STIM_W = 60;

  // Default signature polynomial (CRC-32) and seed.
  localparam logic [31:0] C880_POLY = 32'h04C11DB7;
  localparam logic [31:0] C880_SEED = 32'h0000_0000;

  // Widest vector popcount accepts; callers zero-extend into it.
  localparam int POPCNT_MAX_W = 128;

  // Number of set bits in v (result fits in 8 bits for up to 128 inputs).
  function automatic logic [7:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/c880_resp_misr_step.sv
// One combinational MISR/LFSR step: shift left, fold POLY in when the
// shifted-out MSB is set, then XOR in the zero-extended data word.
module misr_step
  import c880_tb_pkg::*;
#(
  parameter int               SIG_W  = 32,
  parameter int               DATA_W = C880_RESP_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(C880_POLY)
) (
  input  logic [SIG_W-1:0]  sig_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  sig_out
);

  logic             w_fb;
  logic [SIG_W-1:0] w_data_ext;

  assign w_fb       = sig_in[SIG_W-1];
  assign w_data_ext = SIG_W'(data_in);

  // Bit 0 receives only feedback and data; the shift brings in a zero.
  assign sig_out[0] = (w_fb & POLY[0]) ^ w_data_ext[0];

  // Remaining bits take their lower neighbour plus feedback and data.
  for (genvar gi = 1; gi < SIG_W; gi++) begin : g_bit
    assign sig_out[gi] = sig_in[gi-1] ^ (w_fb & POLY[gi]) ^ w_data_ext[gi];
  end

endmodule

// File: rtl/c880_resp_misr.sv
// Response compactor for the c880 bench: folds each accepted 26-bit output
// word into a MISR signature, counts output toggles, and flags a golden
// compare once the programmed number of patterns has been absorbed.
module c880_resp_misr
  import c880_tb_pkg::*;
#(
  parameter int               RESP_W = C880_RESP_W,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(C880_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(C880_SEED),
  parameter int               CNT_W  = 16
) (
  input  logic               CK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_patterns,
  input  logic [SIG_W-1:0]   golden,
  input  logic               resp_valid,
  input  logic [RESP_W-1:0]  resp_data,
  output logic               resp_ready,
  output logic               busy,
  output logic               done,
  output logic [SIG_W-1:0]   signature,
  output logic               match,
  output logic [CNT_W-1:0]   pattern_cnt,
  output logic [CNT_W+4:0]   toggle_cnt
);

  localparam int TOG_W = CNT_W + 5;

  misr_state_t       r_state;
  misr_state_t       r_state_next;
  logic [SIG_W-1:0]  r_sig;
  logic [SIG_W-1:0]  r_golden;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_num;
  logic [TOG_W-1:0]  r_tog;
  logic [RESP_W-1:0] r_prev;

  logic              w_capture;
  logic              w_xfer;
  logic              w_start_ok;
  logic              w_last;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [SIG_W-1:0]  w_sig_step;
  logic [RESP_W-1:0] w_diff;
  logic [7:0]        w_pop;
  logic [TOG_W:0]    w_tog_sum;
  logic [TOG_W-1:0]  w_tog_next;

  assign w_capture  = (r_state == ST_CAPTURE);
  assign w_xfer     = resp_valid && w_capture;
  // A start pulse only re-arms when no run is in progress.
  assign w_start_ok = start && !w_capture;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last     = w_xfer && (w_cnt_inc == r_num);

  misr_step #(
    .SIG_W  (SIG_W),
    .DATA_W (RESP_W),
    .POLY   (POLY)
  ) u_step (
    .sig_in  (r_sig),
    .data_in (resp_data),
    .sig_out (w_sig_step)
  );

  // Toggle accumulation; the sum carries one spare bit so overflow is
  // visible and can be clamped to all-ones.
  assign w_diff     = resp_data ^ r_prev;
  assign w_pop      = popcount(POPCNT_MAX_W'(w_diff));
  assign w_tog_sum  = {1'b0, r_tog} + (TOG_W+1)'(w_pop);
  assign w_tog_next = w_tog_sum[TOG_W] ? {TOG_W{1'b1}} : w_tog_sum[TOG_W-1:0];

  // State register.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Next-state: arm from IDLE/DONE, finish on the transfer that hits the count.
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          r_state_next = (num_patterns == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_last) begin
          r_state_next = ST_DONE;
        end
      end
      default: r_state_next = ST_IDLE;
    endcase
  end

  // Run datapath: clear/latch on start, fold in each accepted response.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_sig    <= SEED;
      r_golden <= '0;
      r_cnt    <= '0;
      r_num    <= '0;
      r_tog    <= '0;
      r_prev   <= '0;
    end else if (w_start_ok) begin
      r_sig    <= SEED;
      r_golden <= golden;
      r_cnt    <= '0;
      r_num    <= num_patterns;
      r_tog    <= '0;
      r_prev   <= '0;
    end else if (w_xfer) begin
      r_sig    <= w_sig_step;
      r_cnt    <= w_cnt_inc;
      r_tog    <= w_tog_next;
      r_prev   <= resp_data;
    end
  end

  assign resp_ready  = w_capture;
  assign busy        = w_capture;
  assign done        = (r_state == ST_DONE);
  assign match       = done && (r_sig == r_golden);
  assign signature   = r_sig;
  assign pattern_cnt = r_cnt;
  assign toggle_cnt  = r_tog;

endmodule

// File: tb/tb_c880_resp_misr.sv
// Self-checking bench for c880_resp_misr: a run-level model checked every
// cycle plus directed literal expectations for each scenario.
module tb_c880_resp_misr;

  localparam int          RW      = 26;
  localparam int          SW      = 32;
  localparam int          CW      = 16;
  localparam int          TW      = CW + 5;
  localparam int          TOG_MAX = (1 << TW) - 1;
  localparam logic [31:0] POLY_M  = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default and the feedback-seed instances.
  logic          start = 1'b0;
  logic [CW-1:0] num_patterns = '0;
  logic [SW-1:0] golden = '0;
  logic          resp_valid = 1'b0;
  logic [RW-1:0] resp_data = '0;

  logic          resp_ready, busy, done, match;
  logic [SW-1:0] signature;
  logic [CW-1:0] pattern_cnt;
  logic [TW-1:0] toggle_cnt;

  logic          f_ready, f_busy, f_done, f_match;
  logic [SW-1:0] f_sig;
  logic [CW-1:0] f_pcnt;
  logic [TW-1:0] f_tog;

  // Wide-response, narrow-counter instance for toggle saturation.
  logic        s_start = 1'b0;
  logic [3:0]  s_num = '0;
  logic [39:0] s_golden = '0;
  logic        s_valid = 1'b0;
  logic [39:0] s_data = '0;
  logic        s_ready, s_busy, s_done, s_match;
  logic [39:0] s_sig;
  logic [3:0]  s_pcnt;
  logic [8:0]  s_tog;

  c880_resp_misr u_dut (
    .CK(clk), .RST_N(rst_n), .start(start), .num_patterns(num_patterns),
    .golden(golden), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .done(done), .signature(signature),
    .match(match), .pattern_cnt(pattern_cnt), .toggle_cnt(toggle_cnt)
  );

  c880_resp_misr #(.SEED(32'h8000_0000)) u_fb (
    .CK(clk), .RST_N(rst_n), .start(start), .num_patterns(num_patterns),
    .golden(golden), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(f_ready), .busy(f_busy), .done(f_done), .signature(f_sig),
    .match(f_match), .pattern_cnt(f_pcnt), .toggle_cnt(f_tog)
  );

  c880_resp_misr #(.RESP_W(40), .SIG_W(40), .CNT_W(4)) u_sat (
    .CK(clk), .RST_N(rst_n), .start(s_start), .num_patterns(s_num),
    .golden(s_golden), .resp_valid(s_valid), .resp_data(s_data),
    .resp_ready(s_ready), .busy(s_busy), .done(s_done), .signature(s_sig),
    .match(s_match), .pattern_cnt(s_pcnt), .toggle_cnt(s_tog)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Signature arithmetic: multiply by x modulo the polynomial, add the data.
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [RW-1:0] d);
    logic [32:0] t;
    t = {1'b0, s} * 33'd2;
    if (s >= 32'h8000_0000) t = t ^ {1'b1, POLY_M};
    return t[31:0] ^ {6'd0, d};
  endfunction

  // Run-level model of the default instance.
  logic [31:0]   m_sig = '0;
  logic [31:0]   m_golden = '0;
  int            m_cnt = 0;
  int            m_num = 0;
  int            m_tog = 0;
  logic [RW-1:0] m_prev = '0;
  bit            m_cap = 1'b0;
  bit            m_fin = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sig <= '0; m_golden <= '0; m_cnt <= 0; m_num <= 0; m_tog <= 0;
      m_prev <= '0; m_cap <= 1'b0; m_fin <= 1'b0;
    end else if (start && !m_cap) begin
      m_sig <= '0; m_golden <= golden; m_cnt <= 0; m_num <= int'(num_patterns);
      m_tog <= 0; m_prev <= '0;
      m_cap <= (num_patterns != 0);
      m_fin <= (num_patterns == 0);
    end else if (m_cap && resp_valid) begin
      m_sig  <= m_step(m_sig, resp_data);
      m_cnt  <= m_cnt + 1;
      m_tog  <= (m_tog + $countones(resp_data ^ m_prev) > TOG_MAX) ?
                TOG_MAX : m_tog + $countones(resp_data ^ m_prev);
      m_prev <= resp_data;
      if (m_cnt + 1 == m_num) begin
        m_cap <= 1'b0;
        m_fin <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("signature", signature, m_sig);
      chk("pattern_cnt", pattern_cnt, m_cnt);
      chk("toggle_cnt", toggle_cnt, m_tog);
      chk("resp_ready", resp_ready, m_cap);
      chk("busy", busy, m_cap);
      chk("done", done, m_fin);
      chk("match", match, m_fin && (m_sig == m_golden));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_signature", signature, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_ready", resp_ready, 0);
    rst_n = 1'b1;
    tick();

    // Basic: two patterns, 1 then 0
    num_patterns = 2; golden = 32'h2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy", busy, 1);
    resp_valid = 1'b1; resp_data = 26'h1;
    tick();
    chk("basic_sig1", signature, 32'h1);
    chk("basic_notdone", done, 0);
    resp_data = 26'h0;
    tick();
    resp_valid = 1'b0;
    chk("basic_done", done, 1);
    chk("basic_ready_low", resp_ready, 0);
    chk("basic_sig2", signature, 32'h2);
    chk("basic_toggle", toggle_cnt, 2);
    chk("basic_match", match, 1);

    // Feedback: seed with MSB set, one zero response
    num_patterns = 1; golden = 32'h04C1_1DB7; start = 1'b1;
    tick();
    start = 1'b0; resp_valid = 1'b1; resp_data = '0;
    tick();
    resp_valid = 1'b0;
    chk("fb_sig", f_sig, 32'h04C1_1DB7);
    chk("fb_match", f_match, 1);
    chk("fb_done", f_done, 1);
    chk("fb_main_sig", signature, 32'h0);

    // Zero-length run
    num_patterns = 0; golden = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_ready", resp_ready, 0);
    chk("zero_sig", signature, 32'h0);
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = RW'($urandom);
      tick();
      chk("zero_ready_hold", resp_ready, 0);
      chk("zero_cnt_hold", pattern_cnt, 0);
    end
    resp_valid = 1'b0;

    // 100 patterns with random gaps and a stray start mid-run
    num_patterns = 100; golden = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      resp_valid = ($urandom_range(0, 3) != 0);
      resp_data  = RW'($urandom);
      if (cyc == 40) begin
        start = 1'b1; num_patterns = 7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; resp_valid = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_pattern_cnt", pattern_cnt, 100);

    // Reset in the middle of a run, then a short known run
    num_patterns = 100; start = 1'b1;
    tick();
    start = 1'b0; resp_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      resp_data = RW'($urandom);
      tick();
    end
    resp_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", resp_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sig", signature, 0);
    chk("mid_rst_cnt", pattern_cnt, 0);
    chk("mid_rst_tog", toggle_cnt, 0);
    rst_n = 1'b1;
    tick();
    num_patterns = 3; golden = 32'h3; start = 1'b1;
    tick();
    start = 1'b0; resp_valid = 1'b1;
    resp_data = 26'h1; tick();
    resp_data = 26'h2; tick();
    resp_data = 26'h3; tick();
    resp_valid = 1'b0;
    chk("rerun_sig", signature, 32'h3);
    chk("rerun_tog", toggle_cnt, 4);
    chk("rerun_done", done, 1);
    chk("rerun_match", match, 1);

    // Toggle saturation on the narrow-counter instance
    s_num = 4'd15; s_start = 1'b1;
    tick();
    s_start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_data = (i % 2 == 0) ? {40{1'b1}} : 40'd0;
      tick();
      if (i == 11) chk("sat_tog_480", s_tog, 480);
      if (i == 12) chk("sat_tog_clamp", s_tog, 511);
    end
    s_valid = 1'b0;
    chk("sat_tog_final", s_tog, 511);
    chk("sat_done", s_done, 1);
    chk("sat_cnt", s_pcnt, 15);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
